// File: rtl/mem_access_unit.sv
// Load/store unit between an RV32I-style CPU request port and a single-port
// word RAM. Sub-word stores are done as read-merge-write.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              CS,
  output logic              WE,
  output logic [ADDR_W-1:0] Addr,
  output logic [31:0]       WD,
  input  logic [31:0]       RD
);

  typedef enum logic [2:0] {IDLE, LOAD, MERGE, STORE, RESP} state_e;

  state_e            state_q;
  logic [2:0]        funct3_q;
  logic [1:0]        lane_q;
  logic [15:0]       wdata_q;
  logic              cs_q, we_q, resp_valid_q, resp_err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wd_q, resp_rdata_q;

  logic              legal;
  logic [4:0]        shamt;
  logic [31:0]       rd_shift, load_ext, lane_mask, lane_data, merged;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign CS         = cs_q;
  assign WE         = we_q;
  assign Addr       = addr_q;
  assign WD         = wd_q;

  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000:         legal = 1'b1;
      3'b001:         legal = ~req_addr[0];
      3'b010:         legal = (req_addr[1:0] == 2'b00);
      3'b100:         legal = ~req_we;
      3'b101:         legal = ~req_we & ~req_addr[0];
      default:        legal = 1'b0;
    endcase
  end

  // Lane shift is shared by load extraction and store merge.
  always_comb begin
    shamt    = {lane_q, 3'b000};
    rd_shift = RD >> shamt;
    case (funct3_q)
      3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_ext = {24'h0, rd_shift[7:0]};
      3'b101:  load_ext = {16'h0, rd_shift[15:0]};
      default: load_ext = RD;
    endcase
    lane_mask = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
    lane_data = {16'h0, wdata_q} << shamt;
    merged    = (RD & ~lane_mask) | (lane_data & lane_mask);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      funct3_q     <= '0;
      lane_q       <= '0;
      wdata_q      <= '0;
      cs_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wd_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            lane_q   <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            if (!legal) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              cs_q   <= 1'b1;
              addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
              if (!req_we) begin
                state_q <= LOAD;
              end else if (req_funct3 == 3'b010) begin
                state_q <= STORE;
                we_q    <= 1'b1;
                wd_q    <= req_wdata;
              end else begin
                state_q <= MERGE;
              end
            end
          end
        end
        LOAD: begin
          state_q      <= RESP;
          cs_q         <= 1'b0;
          addr_q       <= '0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= load_ext;
        end
        MERGE: begin
          state_q <= STORE;
          we_q    <= 1'b1;
          wd_q    <= merged;
        end
        STORE: begin
          state_q      <= RESP;
          cs_q         <= 1'b0;
          we_q         <= 1'b0;
          addr_q       <= '0;
          wd_q         <= '0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural falling-edge RAM.
module tb_mem_access_unit;

  localparam int unsigned ADDR_W = 12;

  logic              clock, reset;
  logic              req_valid, req_ready, req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid, resp_err;
  logic [31:0]       resp_rdata;
  logic              CS, WE;
  logic [ADDR_W-1:0] Addr;
  logic [31:0]       WD, RD;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .CS(CS), .WE(WE), .Addr(Addr), .WD(WD), .RD(RD)
  );

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  assign RD = CS ? mem[Addr[ADDR_W-1:2]] : 32'h0;
  always @(negedge clock) if (CS && WE) mem[Addr[ADDR_W-1:2]] <= WD;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          cs;
    int          we;
  } exp_t;
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wd;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   acc_hist[$];
  int   cyc = 0;
  int   acc_cyc = 0;
  int   cs_cnt = 0;
  int   we_cnt = 0;
  int   n_resp = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset) begin
      cs_cnt = 0;
      we_cnt = 0;
    end else begin
      if (req_valid && req_ready) begin
        acc_cyc = cyc + 1;
        acc_hist.push_back(cyc + 1);
        cs_cnt = 0;
        we_cnt = 0;
      end
      if (CS) cs_cnt++;
      if (WE) begin
        we_cnt++;
        if (wr_q.size() > 0) begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", {20'h0, Addr}, {20'h0, w.addr});
          check("wr_data", WD, w.wd);
          check("wr_cs", {31'h0, CS}, 32'd1);
        end else begin
          check("spurious_we", {31'h0, WE}, 32'd0);
        end
      end
      if (resp_valid) begin
        n_resp++;
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("rdata", resp_rdata, e.rdata);
          check("err", {31'h0, resp_err}, {31'h0, e.err});
          check("latency", cyc - acc_cyc + 1, e.lat);
          check("cs_cycles", cs_cnt, e.cs);
          check("we_cycles", we_cnt, e.we);
        end else begin
          check("spurious_resp", {31'h0, resp_valid}, 32'd0);
        end
      end
    end
  end

  function automatic logic is_legal(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] a);
    if (we)
      return (f3 == 3'd0) || (f3 == 3'd1 && a[0] == 1'b0) || (f3 == 3'd2 && a[1:0] == 2'b00);
    return (f3 == 3'd0) || (f3 == 3'd4) || ((f3 == 3'd1 || f3 == 3'd5) && a[0] == 1'b0) ||
           (f3 == 3'd2 && a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] w, input logic [1:0] lane, input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0: return b[7] ? {24'hFFFFFF, b} : {24'h0, b};
      3'd4: return {24'h0, b};
      3'd1: return h[15] ? {16'hFFFF, h} : {16'h0, h};
      3'd5: return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_model(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (f3 == 3'd2) r = d;
    else if (f3 == 3'd1) begin
      if (lane[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
    end else begin
      case (lane)
        2'd0: r[7:0]   = d[7:0];
        2'd1: r[15:8]  = d[7:0];
        2'd2: r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end
    return r;
  endfunction

  task automatic push_expect(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                             input logic [31:0] d);
    exp_t e;
    wr_t  w;
    int   idx;
    idx = int'(a[ADDR_W-1:2]);
    e.rdata = 32'h0; e.err = 1'b0; e.lat = 2; e.cs = 1; e.we = 0;
    if (!is_legal(we, f3, a)) begin
      e.err = 1'b1; e.lat = 1; e.cs = 0;
    end else if (!we) begin
      e.rdata = load_model(ref_mem[idx], a[1:0], f3);
    end else begin
      e.we = 1;
      if (f3 != 3'd2) begin e.lat = 3; e.cs = 2; end
      ref_mem[idx] = store_model(ref_mem[idx], a[1:0], f3, d);
      w.addr = {a[ADDR_W-1:2], 2'b00};
      w.wd   = ref_mem[idx];
      wr_q.push_back(w);
    end
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                       input logic [31:0] d);
    int start;
    start = n_resp;
    push_expect(we, f3, a, d);
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (n_resp != start) break;
      @(posedge clock);
      #1;
    end
    check("resp_seen", n_resp - start, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, base;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clock);
    check("rst_cs", {31'h0, CS}, 32'd0);
    check("rst_we", {31'h0, WE}, 32'd0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    check("rst_addr", {20'h0, Addr}, 32'd0);
    check("rst_wd", WD, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    check("rst_ready", {31'h0, req_ready}, 32'd1);

    issue(1'b1, 3'd2, 12'h010, 32'hDEADBEEF);
    issue(1'b0, 3'd2, 12'h010, 32'h0);

    issue(1'b1, 3'd2, 12'h010, 32'h11223344);
    issue(1'b1, 3'd0, 12'h013, 32'h000000AA);
    issue(1'b0, 3'd4, 12'h013, 32'h0);
    issue(1'b0, 3'd0, 12'h013, 32'h0);

    issue(1'b1, 3'd2, 12'h010, 32'h11223344);
    issue(1'b1, 3'd1, 12'h012, 32'h00008001);
    issue(1'b0, 3'd2, 12'h010, 32'h0);
    issue(1'b0, 3'd1, 12'h012, 32'h0);
    issue(1'b0, 3'd5, 12'h012, 32'h0);

    issue(1'b0, 3'd2, 12'h011, 32'h0);
    issue(1'b1, 3'd1, 12'h013, 32'h0000FFFF);
    issue(1'b0, 3'd3, 12'h010, 32'h0);
    issue(1'b1, 3'd4, 12'h014, 32'h12345678);
    issue(1'b0, 3'd2, 12'h010, 32'h0);

    for (int i = 0; i < 24; i++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end

    // Reset during the write cycle of a byte store must abort without a response.
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 12'h011; req_wdata = 32'h55;
    @(posedge clock); #1 req_valid = 1'b0;
    @(posedge clock); #1;
    check("abort_we_pre", {31'h0, WE}, 32'd1);
    start = n_resp;
    reset = 1'b1;
    #1;
    check("abort_cs", {31'h0, CS}, 32'd0);
    check("abort_we", {31'h0, WE}, 32'd0);
    check("abort_addr", {20'h0, Addr}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("abort_no_resp", n_resp - start, 0);
    check("abort_ready", {31'h0, req_ready}, 32'd1);
    wr_q.delete();
    issue(1'b0, 3'd2, 12'h010, 32'h0);

    // Held request: second load is accepted only once the unit is idle again.
    base  = acc_hist.size();
    start = n_resp;
    push_expect(1'b0, 3'd2, 12'h010, 32'h0);
    push_expect(1'b0, 3'd2, 12'h014, 32'h0);
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 12'h010;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (acc_hist.size() > base) break;
    end
    req_addr = 12'h014;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (acc_hist.size() > base + 1) break;
    end
    req_valid = 1'b0;
    check("b2b_accepts", acc_hist.size() - base, 2);
    if (acc_hist.size() >= base + 2)
      check("b2b_gap", acc_hist[base + 1] - acc_hist[base], 3);
    repeat (8) @(posedge clock);
    #1;
    check("b2b_resps", n_resp - start, 2);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one parameter: ADDR_W, default 12, byte-address width driven to the RAM.
REQ-002 The block SHALL have port `clock`, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port `req_valid`, input, 1 bit: CPU access request.
REQ-005 The block SHALL have port `req_ready`, output, 1 bit: block can accept a request.
REQ-006 The block SHALL have port `req_we`, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port `req_funct3`, input, 3 bits: RV32I size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 The block SHALL have port `req_addr`, input, ADDR_W bits: byte address.
REQ-009 The block SHALL have port `req_wdata`, input, 32 bits: store data, right-aligned.
REQ-010 The block SHALL have port `resp_valid`, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port `resp_rdata`, output, 32 bits: extended load result; 0 for stores and errors.
REQ-012 The block SHALL have port `resp_err`, output, 1 bit: misaligned or illegal access; qualified by resp_valid.
REQ-013 The block SHALL have port `CS`, output, 1 bit: RAM chip-select.
REQ-014 The block SHALL have port `WE`, output, 1 bit: RAM write-enable; the RAM writes on the falling edge while CS=1 and WE=1.
REQ-015 The block SHALL have port `Addr`, output, ADDR_W bits: RAM address, word-aligned (bits [1:0] = 0).
REQ-016 The block SHALL have port `WD`, output, 32 bits: RAM write data.
REQ-017 The block SHALL have port `RD`, input, 32 bits: RAM read data, combinational from Addr while CS=1.

Function
REQ-018 The FSM SHALL have exactly these states: IDLE, LOAD, MERGE, STORE, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a rising edge with req_valid=1 in IDLE, and all req_* fields SHALL be latched at that edge.
REQ-020 A request SHALL be legal iff the following hold:
- funct3 is in {000, 001, 010, 100, 101} for loads, or in {000, 001, 010} for stores;
- H/HU has addr[0]=0;
- W has addr[1:0]=00.
REQ-021 From IDLE on acceptance, the FSM SHALL transition as follows:
- illegal request -> RESP with resp_err=1;
- load -> LOAD;
- SW -> STORE;
- SB/SH -> MERGE.
REQ-022 In LOAD and MERGE the block SHALL drive CS=1, WE=0, and Addr={addr[ADDR_W-1:2],2'b00}, and SHALL capture RD at the end-of-state rising edge.
REQ-023 LOAD SHALL extract the byte/half selected by addr[1:0] (little-endian: byte n = bits [8n+7:8n]), sign-extend for B/H, zero-extend for BU/HU, pass W unchanged, and go to RESP.
REQ-024 MERGE SHALL replace only the addressed byte lane(s) of captured RD with req_wdata[7:0] (SB) or req_wdata[15:0] (SH), and go to STORE.
REQ-025 In STORE the block SHALL drive CS=1, WE=1, the same Addr, and WD = merged word (SB/SH) or req_wdata (SW) for exactly one full cycle, then go to RESP.
REQ-026 In RESP the block SHALL assert resp_valid=1 for exactly one cycle with resp_rdata/resp_err, then return to IDLE.
REQ-027 Latency from the accept edge to the resp_valid cycle SHALL be as follows:
- error: 1 cycle;
- load: 2 cycles;
- SW: 2 cycles;
- SB/SH: 3 cycles.
REQ-028 In IDLE and RESP the block SHALL drive CS=0, WE=0, Addr=0, WD=0; no RAM access SHALL occur for illegal requests.
REQ-029 WE SHALL never be 1 outside STORE, and CS SHALL never be 1 in IDLE or RESP.
REQ-030 req_valid SHALL be ignored outside IDLE; there SHALL be no request buffering, and back-to-back requests SHALL each see req_ready=1 only after RESP.

Reset
REQ-031 On reset=1, asynchronously and without waiting for clock: state=IDLE; CS, WE, resp_valid, resp_err=0; Addr, WD, resp_rdata, and internal latches=0; req_ready=1 after reset deasserts.
REQ-032 Reset mid-operation SHALL drop CS/WE immediately, abort the access, and produce no resp_valid.

Verification
REQ-033 Scenario: SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> STORE cycle shows CS=1, WE=1, Addr=0x010, WD=0xDEADBEEF; LW resp_rdata=0xDEADBEEF, resp_err=0, 2-cycle latency.
REQ-034 Scenario: word 0x010 = 0x11223344; SB 0x013 data 0x000000AA -> MERGE then STORE with WD=0xAA223344; LBU 0x013 -> 0x000000AA; LB 0x013 -> 0xFFFFFFAA.
REQ-035 Scenario: SH 0x012 data 0x8001 on 0x11223344 -> memory word 0x80013344; LH 0x012 -> 0xFFFF8001; LHU 0x012 -> 0x00008001.
REQ-036 Scenario: LW 0x011, SH 0x013, load funct3=011 -> each gives resp_valid with resp_err=1 after 1 cycle, CS never asserted, memory unchanged.
REQ-037 Scenario: assert reset during the STORE cycle of SB -> CS/WE fall same timestep, no resp_valid, req_ready=1 after reset release.
REQ-038 Scenario: req_valid held high continuously for LW, LW -> second accepted only on the edge following RESP; exactly two resp_valid pulses.
